// File: rtl/seg7_scan_driver.sv
// Purpose: time-multiplexed 4-digit active-low 7-segment scanner with per-digit blank/blink (optional SEG7_LAMP_TEST_EN adds lamp_test).
// Latency: all outputs registered; the frame snapshot is taken and shown for digit 0 on the same edge, SCAN_DIV cycles after reset.
// Backpressure: none; free-running scan, inputs are sampled once per frame and mid-frame changes are ignored.
module seg7_scan_driver #(
  parameter int SCAN_DIV  = 25000,
  parameter int BLINK_DIV = 25000000,
  parameter int CNT_W     = 25
) (
  input  logic       clk,
  input  logic       rst,
`ifdef SEG7_LAMP_TEST_EN
  input  logic       lamp_test,
`endif
  input  logic [3:0] code3,
  input  logic [3:0] code2,
  input  logic [3:0] code1,
  input  logic [3:0] code0,
  input  logic [3:0] blank_mask,
  input  logic [3:0] blink_mask,
  output logic [3:0] DIGIT,
  output logic [6:0] DISPLAY,
  output logic       frame_tick
);

  localparam logic [CNT_W-1:0] SCAN_LAST  = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] BLINK_LAST = CNT_W'(BLINK_DIV - 1);

  logic [CNT_W-1:0] scan_cnt;
  logic [CNT_W-1:0] blink_cnt;
  logic             blink_phase;
  logic [1:0]       idx;
  logic [15:0]      snap_codes;
  logic [3:0]       snap_blank;
  logic [3:0]       snap_blink;

  logic             slot_adv;
  logic             frame_start;
  logic [1:0]       idx_nxt;
  logic [15:0]      codes_src;
  logic [3:0]       blank_src;
  logic [3:0]       blink_src;
  logic [3:0]       sel_code;
  logic             sel_dark;
  logic [6:0]       seg_dec;
  logic [6:0]       disp_nxt;
  logic [3:0]       digit_nxt;

  // Next-slot selection and decode; the frame-start edge uses the live inputs
  // because those are exactly what the snapshot captures on that edge.
  always_comb begin
    slot_adv    = (scan_cnt == SCAN_LAST);
    frame_start = slot_adv && (idx == 2'd3);
    idx_nxt     = idx + 2'd1;
    codes_src   = frame_start ? {code3, code2, code1, code0} : snap_codes;
    blank_src   = frame_start ? blank_mask : snap_blank;
    blink_src   = frame_start ? blink_mask : snap_blink;
    sel_code    = codes_src[{idx_nxt, 2'b00} +: 4];
    // Blank wins over blink; blink only darkens during the off phase.
    sel_dark    = blank_src[idx_nxt] | (blink_src[idx_nxt] & blink_phase);
    seg_dec     = 7'h7F;
    case (sel_code)
      4'd0:    seg_dec = 7'b100_0000;
      4'd1:    seg_dec = 7'b111_1001;
      4'd2:    seg_dec = 7'b010_0100;
      4'd3:    seg_dec = 7'b011_0000;
      4'd4:    seg_dec = 7'b001_1001;
      4'd5:    seg_dec = 7'b001_0010;
      4'd6:    seg_dec = 7'b000_0010;
      4'd7:    seg_dec = 7'b111_1000;
      4'd8:    seg_dec = 7'b000_0000;
      4'd9:    seg_dec = 7'b001_0000;
      4'd10:   seg_dec = 7'b000_1100; // P
      4'd11:   seg_dec = 7'b101_1100; // UP
      4'd12:   seg_dec = 7'b110_0011; // DOWN
      4'd13:   seg_dec = 7'b011_1111; // dash
      default: seg_dec = 7'b111_1111;
    endcase
    disp_nxt = sel_dark ? 7'h7F : seg_dec;
`ifdef SEG7_LAMP_TEST_EN
    if (lamp_test) begin
      disp_nxt = 7'h00;
    end
`endif
    digit_nxt = ~(4'b0001 << idx_nxt);
  end

  // Slot timer: wraps every SCAN_DIV cycles, the wrap cycle advances the digit.
  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt <= '0;
    end else if (slot_adv) begin
      scan_cnt <= '0;
    end else begin
      scan_cnt <= scan_cnt + CNT_W'(1);
    end
  end

  // Free-running blink timer, independent of the scan.
  always_ff @(posedge clk) begin
    if (rst) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (blink_cnt == BLINK_LAST) begin
      blink_cnt   <= '0;
      blink_phase <= ~blink_phase;
    end else begin
      blink_cnt <= blink_cnt + CNT_W'(1);
    end
  end

  // Digit index and once-per-frame snapshot of codes and masks.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx        <= 2'd3;
      snap_codes <= 16'hFFFF;
      snap_blank <= 4'hF;
      snap_blink <= 4'hF;
    end else if (slot_adv) begin
      idx <= idx_nxt;
      if (frame_start) begin
        snap_codes <= {code3, code2, code1, code0};
        snap_blank <= blank_mask;
        snap_blink <= blink_mask;
      end
    end
  end

  // Output stage: digit enable and segments switch together on the slot edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      DIGIT      <= 4'hF;
      DISPLAY    <= 7'h7F;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= frame_start;
      if (slot_adv) begin
        DIGIT   <= digit_nxt;
        DISPLAY <= disp_nxt;
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: directed scenarios plus random codes/masks/resets
// checked every cycle against a time-arithmetic reference model.
// Build with SEG7_LAMP_TEST_EN to also exercise lamp_test.
module tb_seg7_scan_driver;

  localparam int SD = 4;
  localparam int BD = 64;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       lamp = 1'b0;
  logic [3:0] c3 = 4'd0, c2 = 4'd0, c1 = 4'd0, c0 = 4'd0;
  logic [3:0] blank_m = 4'd0, blink_m = 4'd0;
  logic [3:0] DIGIT;
  logic [6:0] DISPLAY;
  logic       frame_tick;

  int checks = 0;
  int errors = 0;

  seg7_scan_driver #(.SCAN_DIV(SD), .BLINK_DIV(BD), .CNT_W(25)) dut (
    .clk        (clk),
    .rst        (rst),
`ifdef SEG7_LAMP_TEST_EN
    .lamp_test  (lamp),
`endif
    .code3      (c3),
    .code2      (c2),
    .code1      (c1),
    .code0      (c0),
    .blank_mask (blank_m),
    .blink_mask (blink_m),
    .DIGIT      (DIGIT),
    .DISPLAY    (DISPLAY),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  // Segment table straight from the symbol list.
  logic [6:0] dec_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h0C, 7'h5C, 7'h63, 7'h3F, 7'h7F, 7'h7F};

  // Reference model: k = clock edges since the reset edge. Slot edges are
  // multiples of SD; the digit shown after slot n is (3+n) mod 4; a frame starts
  // when that digit is 0. Blink phase before edge k is ((k-1)/BD) mod 2.
  int         k = 0;
  int         snap_code [4];
  logic [3:0] snap_blank, snap_blink;
  logic [3:0] e_dig = 4'hF;
  logic [6:0] e_disp = 7'h7F;
  logic       e_ft = 1'b0;

  task automatic model_edge();
    int d;
    int ph;
    if (rst) begin
      k = 0;
      e_dig = 4'hF; e_disp = 7'h7F; e_ft = 1'b0;
      for (int i = 0; i < 4; i++) snap_code[i] = 15;
      snap_blank = 4'hF; snap_blink = 4'hF;
    end else begin
      k++;
      e_ft = 1'b0;
      if (k % SD == 0) begin
        d = (3 + k / SD) % 4;
        if (d == 0) begin
          snap_code[3] = c3; snap_code[2] = c2; snap_code[1] = c1; snap_code[0] = c0;
          snap_blank = blank_m; snap_blink = blink_m;
          e_ft = 1'b1;
        end
        ph = ((k - 1) / BD) % 2;
        e_dig = 4'hF;
        e_dig[d] = 1'b0;
        if (lamp) e_disp = 7'h00;
        else if (snap_blank[d] || (snap_blink[d] && ph == 1)) e_disp = 7'h7F;
        else e_disp = dec_tab[snap_code[d]];
      end
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h (k=%0d)", tag, obs, exp, k);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    chk("DIGIT", {4'h0, DIGIT}, {4'h0, e_dig});
    chk("DISPLAY", {1'b0, DISPLAY}, {1'b0, e_disp});
    chk("frame_tick", {7'h0, frame_tick}, {7'h0, e_ft});
  endtask

  task automatic run_to(input int target);
    int guard = 0;
    while (k < target && guard < 2000) begin
      tick();
      guard++;
    end
    if (k != target) begin
      errors++;
      $error("FAIL run_to: reached k=%0d expected %0d", k, target);
    end
  endtask

  task automatic first_frame_checks();
    run_to(3);
    chk("dark_before_first_slot", {4'h0, DIGIT}, 8'h0F);
    chk("dark_disp_before_first_slot", {1'b0, DISPLAY}, 8'h7F);
    run_to(4);
    chk("slot0_digit", {4'h0, DIGIT}, 8'h0E);
    chk("slot0_disp", {1'b0, DISPLAY}, 8'h30);
    chk("slot0_ftick", {7'h0, frame_tick}, 8'h01);
    run_to(5);
    chk("ftick_one_cycle", {7'h0, frame_tick}, 8'h00);
    run_to(8);
    chk("slot1_digit", {4'h0, DIGIT}, 8'h0D);
    chk("slot1_disp", {1'b0, DISPLAY}, 8'h24);
    run_to(12);
    chk("slot2_digit", {4'h0, DIGIT}, 8'h0B);
    chk("slot2_disp", {1'b0, DISPLAY}, 8'h79);
    run_to(16);
    chk("slot3_digit", {4'h0, DIGIT}, 8'h07);
    chk("slot3_disp", {1'b0, DISPLAY}, 8'h5C);
    run_to(20);
    chk("ftick_period16", {7'h0, frame_tick}, 8'h01);
  endtask

  initial begin
    // Reset for three cycles, then UP 1 2 3 with no masks.
    c3 = 4'd11; c2 = 4'd1; c1 = 4'd2; c0 = 4'd3;
    rst = 1'b1;
    repeat (3) tick();
    chk("reset_digit", {4'h0, DIGIT}, 8'h0F);
    chk("reset_disp", {1'b0, DISPLAY}, 8'h7F);
    chk("reset_ftick", {7'h0, frame_tick}, 8'h00);
    rst = 1'b0;
    first_frame_checks();

    // Mid-frame change of code0 is held off until the next snapshot.
    run_to(24);
    c0 = 4'd8;
    run_to(32);
    chk("midframe_digit3_unaffected", {1'b0, DISPLAY}, 8'h5C);
    run_to(36);
    chk("new_code0_after_frame", {1'b0, DISPLAY}, 8'h00);

    // Blink on digit 0 with all nines, then blank plus blink.
    c3 = 4'd9; c2 = 4'd9; c1 = 4'd9; c0 = 4'd9;
    blink_m = 4'b0001;
    repeat (320) tick();
    blank_m = 4'b0001;
    repeat (140) tick();
    blank_m = 4'b0000; blink_m = 4'b0000;

`ifdef SEG7_LAMP_TEST_EN
    lamp = 1'b1; blank_m = 4'hF;
    repeat (40) tick();
    chk("lamp_on_disp", {1'b0, DISPLAY}, 8'h00);
    lamp = 1'b0;
    repeat (40) tick();
    chk("lamp_off_dark", {1'b0, DISPLAY}, 8'h7F);
    blank_m = 4'h0;
`endif

    // Reset while digit 2 is lit; the sequence restarts as after power-up.
    c3 = 4'd11; c2 = 4'd1; c1 = 4'd2; c0 = 4'd3;
    begin
      int guard = 0;
      while (k % 16 != 13 && guard < 100) begin
        tick();
        guard++;
      end
    end
    chk("pre_reset_digit2", {4'h0, DIGIT}, 8'h0B);
    rst = 1'b1;
    tick();
    chk("midreset_digit", {4'h0, DIGIT}, 8'h0F);
    chk("midreset_disp", {1'b0, DISPLAY}, 8'h7F);
    rst = 1'b0;
    first_frame_checks();

    // Random codes, masks, occasional resets (and lamp test when built in).
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 7) == 0) begin
        c3 = 4'($urandom); c2 = 4'($urandom); c1 = 4'($urandom); c0 = 4'($urandom);
        blank_m = 4'($urandom & $urandom);
        blink_m = 4'($urandom);
`ifdef SEG7_LAMP_TEST_EN
        lamp = ($urandom_range(0, 9) == 0);
`endif
      end
      rst = ($urandom_range(0, 599) == 0);
      tick();
    end
    rst = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
